// File: rtl/vga_pkg.sv
// Shared timing defaults and pixel types for the VGA controller and the board renderer.
package vga_pkg;

    localparam int unsigned DIV_DEF    = 32'd2;
    localparam int unsigned H_VIS_DEF  = 32'd640;
    localparam int unsigned H_FP_DEF   = 32'd16;
    localparam int unsigned H_SYNC_DEF = 32'd96;
    localparam int unsigned H_BP_DEF   = 32'd48;
    localparam int unsigned V_VIS_DEF  = 32'd480;
    localparam int unsigned V_FP_DEF   = 32'd10;
    localparam int unsigned V_SYNC_DEF = 32'd2;
    localparam int unsigned V_BP_DEF   = 32'd33;

    localparam int unsigned H_TOTAL = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/controlador_vga_if.sv
// Controller <-> renderer/DAC signal bundle; master is the timing generator.
interface controlador_vga_if;

    vga_pkg::coord_t x;
    vga_pkg::coord_t y;
    logic            activo;
    logic            fin_cuadro;
    logic            vga_clk;
    logic            hsync_n;
    logic            vsync_n;
    logic            blank_n;
    logic            sync_n;
    logic [7:0]      red;
    logic [7:0]      green;
    logic [7:0]      blue;
    logic [7:0]      red_in;
    logic [7:0]      green_in;
    logic [7:0]      blue_in;

    modport master (
        input  red_in, green_in, blue_in,
        output x, y, activo, fin_cuadro, vga_clk, hsync_n, vsync_n,
               blank_n, sync_n, red, green, blue
    );

    modport slave (
        output red_in, green_in, blue_in,
        input  x, y, activo, fin_cuadro, vga_clk, hsync_n, vsync_n,
               blank_n, sync_n, red, green, blue
    );

endinterface

// File: rtl/divisor_pixel.sv
// Divides the system clock down to the pixel rate: one-clk pix_en strobe plus a registered DAC clock.
module divisor_pixel #(
    parameter int unsigned DIV = 32'd2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en,
    output logic vga_clk
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST_C = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] HALF_C = CW'(DIV / 32'd2);

    logic [CW-1:0] div_cnt_r;
    logic [CW-1:0] div_nxt_s;
    logic          vga_clk_r;

    // Next divider count, wrapping at DIV-1
    always_comb begin
        div_nxt_s = div_cnt_r;
        if (div_cnt_r == LAST_C) begin
            div_nxt_s = {CW{1'b0}};
        end else begin
            div_nxt_s = div_cnt_r + CW'(1);
        end
    end

    // Divider state; vga_clk is precomputed from the next count so it tracks div_cnt exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {CW{1'b0}};
            vga_clk_r <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            vga_clk_r <= (div_nxt_s >= HALF_C);
        end
    end

    assign pix_en  = (div_cnt_r == LAST_C);
    assign vga_clk = vga_clk_r;

endmodule

// File: rtl/controlador_vga.sv
// VGA scan counters and registered DAC output stage; sync, blank and colour share one pixel of latency.
module controlador_vga
    import vga_pkg::*;
#(
    parameter int unsigned DIV    = DIV_DEF,
    parameter int unsigned H_VIS  = H_VIS_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_VIS  = V_VIS_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    controlador_vga_if.master   bus
);

    localparam coord_t H_VIS_C    = coord_t'(H_VIS);
    localparam coord_t H_LAST_C   = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 32'd1);
    localparam coord_t HS_START_C = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END_C   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t V_VIS_C    = coord_t'(V_VIS);
    localparam coord_t V_PRE_C    = coord_t'(V_VIS - 32'd1);
    localparam coord_t V_LAST_C   = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 32'd1);
    localparam coord_t VS_START_C = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END_C   = coord_t'(V_VIS + V_FP + V_SYNC);

    logic   pix_en_s;
    logic   vga_clk_s;
    coord_t x_r;
    coord_t y_r;
    logic   activo_s;
    logic   h_wrap_s;
    logic   hsync_s;
    logic   vsync_s;
    rgb_t   pix_in_s;
    rgb_t   pix_r;
    logic   hsync_n_r;
    logic   vsync_n_r;
    logic   blank_n_r;
    logic   fin_cuadro_r;

    divisor_pixel #(.DIV(DIV)) u_divisor (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en_s),
        .vga_clk (vga_clk_s)
    );

    // Decode of the current (pre-increment) scan position
    always_comb begin
        activo_s = (x_r < H_VIS_C) && (y_r < V_VIS_C);
        h_wrap_s = (x_r == H_LAST_C);
        hsync_s  = (x_r >= HS_START_C) && (x_r < HS_END_C);
        vsync_s  = (y_r >= VS_START_C) && (y_r < VS_END_C);
        if (activo_s) begin
            pix_in_s = '{r: bus.red_in, g: bus.green_in, b: bus.blue_in};
        end else begin
            pix_in_s = rgb_t'(24'h00_0000);
        end
    end

    // Horizontal/vertical scan counters, advanced once per pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= 10'd0;
            y_r <= 10'd0;
        end else if (pix_en_s) begin
            if (h_wrap_s) begin
                x_r <= 10'd0;
                y_r <= (y_r == V_LAST_C) ? 10'd0 : y_r + 10'd1;
            end else begin
                x_r <= x_r + 10'd1;
            end
        end
    end

    // Output stage: syncs, blank and colour all latched on the same pix_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n_r <= 1'b1;
            vsync_n_r <= 1'b1;
            blank_n_r <= 1'b0;
            pix_r     <= rgb_t'(24'h00_0000);
        end else if (pix_en_s) begin
            hsync_n_r <= ~hsync_s;
            vsync_n_r <= ~vsync_s;
            blank_n_r <= activo_s;
            pix_r     <= pix_in_s;
        end
    end

    // Frame strobe: high while the counters sit at the first blanking line, column 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_cuadro_r <= 1'b0;
        end else begin
            fin_cuadro_r <= pix_en_s && h_wrap_s && (y_r == V_PRE_C);
        end
    end

    assign bus.x          = x_r;
    assign bus.y          = y_r;
    assign bus.activo     = activo_s;
    assign bus.fin_cuadro = fin_cuadro_r;
    assign bus.vga_clk    = vga_clk_s;
    assign bus.hsync_n    = hsync_n_r;
    assign bus.vsync_n    = vsync_n_r;
    assign bus.blank_n    = blank_n_r;
    assign bus.sync_n     = 1'b0;
    assign bus.red        = pix_r.r;
    assign bus.green      = pix_r.g;
    assign bus.blue       = pix_r.b;

endmodule

// File: tb/tb_controlador_vga.sv
// Self-checking bench for controlador_vga on a shrunken 15x8 raster (8x4 visible) so whole frames stay short.
module tb_controlador_vga;
    import vga_pkg::*;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = 2 * HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        activo;
        logic        fin;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        sync_n;
        logic [23:0] rgb;
    } obs_t;

    typedef struct {
        int          n;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fin;
        logic [23:0] rgb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cur_mode = 1'b0;
    rgb_t cur_c = rgb_t'(24'h00_0000);
    logic held_mode;
    rgb_t held_c;
    int   n, checks, failures;
    logic prev_hs, prev_vs;
    int   hs_fall0, hs_fall1, hs_rise0, vs_fall0, vs_rise0, fin_cnt;
    int   fin_n[4];
    vec_t tbl[19];

    controlador_vga_if bus();

    controlador_vga #(
        .DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Renderer stand-in: constant colour or {x, y, 0x55}
    assign bus.red_in   = cur_mode ? cur_c.r : bus.x[7:0];
    assign bus.green_in = cur_mode ? cur_c.g : bus.y[7:0];
    assign bus.blue_in  = cur_mode ? cur_c.b : 8'h55;

    function automatic obs_t sample();
        obs_t o;
        o.x = bus.x; o.y = bus.y; o.activo = bus.activo; o.fin = bus.fin_cuadro;
        o.vclk = bus.vga_clk; o.hs = bus.hsync_n; o.vs = bus.vsync_n;
        o.bl = bus.blank_n; o.sync_n = bus.sync_n;
        o.rgb = {bus.red, bus.green, bus.blue};
        return o;
    endfunction

    // Expected state n clk edges after reset release (pixel edge on every even n)
    function automatic obs_t model(int nn, logic cm, rgb_t cv);
        obs_t e;
        int p, q, xq, yq;
        p = nn / 2;
        e.x = 10'(p % HT);
        e.y = 10'((p / HT) % VT);
        e.activo = ((p % HT) < HV) && (((p / HT) % VT) < VV);
        e.fin = ((nn % FRAME_CLK) == 2 * HT * VV);
        e.vclk = 1'((nn % 2) == 1);
        e.sync_n = 1'b0;
        if (nn < 2) begin
            e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.rgb = 24'h0;
        end else begin
            q = p - 1;
            xq = q % HT;
            yq = (q / HT) % VT;
            e.hs = !(xq >= HV + HF && xq < HV + HF + HS);
            e.vs = !(yq >= VV + VF && yq < VV + VF + VS);
            e.bl = (xq < HV) && (yq < VV);
            if (!e.bl) e.rgb = 24'h0;
            else if (cm) e.rgb = cv;
            else e.rgb = {8'(xq), 8'(yq), 8'h55};
        end
        return e;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%h exp=%h", name, n, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic restart_tracking();
        n = 0; held_mode = cur_mode; held_c = cur_c;
        prev_hs = 1'b1; prev_vs = 1'b1;
        hs_fall0 = -1; hs_fall1 = -1; hs_rise0 = -1; vs_fall0 = -1; vs_rise0 = -1;
        fin_cnt = 0;
    endtask

    // Advance one clk, compare everything against the model, and log sync/frame edges
    task automatic step();
        obs_t o;
        @(posedge clk);
        @(negedge clk);
        n++;
        if (n % 2 == 0) begin
            held_mode = cur_mode;
            held_c = cur_c;
        end
        o = sample();
        check_obs("scan", o, model(n, held_mode, held_c));
        if (prev_hs && !o.hs) begin
            if (hs_fall0 < 0) hs_fall0 = n;
            else if (hs_fall1 < 0) hs_fall1 = n;
        end
        if (!prev_hs && o.hs && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = n;
        if (prev_vs && !o.vs && vs_fall0 < 0) vs_fall0 = n;
        if (!prev_vs && o.vs && vs_fall0 >= 0 && vs_rise0 < 0) vs_rise0 = n;
        if (o.fin) begin
            if (fin_cnt < 4) fin_n[fin_cnt] = n;
            fin_cnt++;
        end
        prev_hs = o.hs;
        prev_vs = o.vs;
    endtask

    initial begin
        obs_t o, rst_obs;
        checks = 0;
        failures = 0;
        rst_obs = '{x: 10'd0, y: 10'd0, activo: 1'b1, fin: 1'b0, vclk: 1'b0, hs: 1'b1,
                    vs: 1'b1, bl: 1'b0, sync_n: 1'b0, rgb: 24'h0};

        // n, x, y, hsync_n, vsync_n, blank_n, fin_cuadro, rgb (hand-computed, 15x8 raster)
        tbl[0]  = '{0,   10'd0,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[1]  = '{1,   10'd0,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[2]  = '{2,   10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000055};
        tbl[3]  = '{22,  10'd11, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[4]  = '{27,  10'd13, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[5]  = '{28,  10'd14, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[6]  = '{30,  10'd0,  10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[7]  = '{32,  10'd1,  10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000155};
        tbl[8]  = '{46,  10'd8,  10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h070155};
        tbl[9]  = '{84,  10'd12, 10'd2, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[10] = '{100, 10'd5,  10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 24'h040355};
        tbl[11] = '{120, 10'd0,  10'd4, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000000};
        tbl[12] = '{121, 10'd0,  10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[13] = '{152, 10'd1,  10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[14] = '{182, 10'd1,  10'd6, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[15] = '{212, 10'd1,  10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[16] = '{238, 10'd14, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[17] = '{240, 10'd0,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[18] = '{242, 10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000055};

        // Power-on reset held 10 clk
        repeat (10) @(posedge clk);
        @(negedge clk);
        n = 0;
        check_obs("reset_hold", sample(), rst_obs);
        rst_n = 1'b1;
        restart_tracking();
        #1;
        check_obs("scan", sample(), model(0, 1'b0, cur_c));

        // Frame 1: renderer-model colours, directed table points
        for (int i = 0; i < 19; i++) begin
            while (n < tbl[i].n) step();
            o = sample();
            checks++;
            if ({o.x, o.y, o.hs, o.vs, o.bl, o.fin, o.rgb} !==
                {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].fin, tbl[i].rgb}) begin
                failures++;
                $display("FAIL vec%0d n=%0d got x=%0d y=%0d hs=%b vs=%b bl=%b fin=%b rgb=%h exp x=%0d y=%0d hs=%b vs=%b bl=%b fin=%b rgb=%h",
                         i, n, o.x, o.y, o.hs, o.vs, o.bl, o.fin, o.rgb, tbl[i].x, tbl[i].y,
                         tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].fin, tbl[i].rgb);
            end
        end

        // Frame 2: constant colours, switched mid-frame
        cur_mode = 1'b1;
        cur_c = rgb_t'(24'hFF00AA);
        while (n < 480) begin
            step();
            if (n == 320) cur_c = rgb_t'(24'hAAFF00);
            if (n == 400) cur_c = rgb_t'(24'h00AAFF);
        end

        // Sync widths/periods and frame strobes over the two frames
        check_int("hs_first_fall", hs_fall0, 22);
        check_int("hs_low_clk", hs_rise0 - hs_fall0, 2 * HS);
        check_int("hs_period_clk", hs_fall1 - hs_fall0, 2 * HT);
        check_int("vs_first_fall", vs_fall0, 152);
        check_int("vs_low_clk", vs_rise0 - vs_fall0, 2 * HT * VS);
        check_int("fin_count", fin_cnt, 2);
        check_int("fin_first", fin_n[0], 120);
        check_int("fin_spacing", fin_n[1] - fin_n[0], FRAME_CLK);

        // Frame 3: renderer model again, reset mid-frame at x=5, y=2
        cur_mode = 1'b0;
        while (n < 550) step();
        check_int("pre_rst_x", int'(bus.x), 5);
        check_int("pre_rst_y", int'(bus.y), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("rst_async", sample(), rst_obs);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_obs("rst_hold2", sample(), rst_obs);
        rst_n = 1'b1;
        restart_tracking();
        #1;
        check_obs("scan", sample(), model(0, 1'b0, cur_c));
        while (n < 125) step();
        check_int("fin_after_rst_count", fin_cnt, 1);
        check_int("fin_after_rst_n", fin_n[0], 120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_vga.md
# controlador_vga

VGA 640×480 @ 60 Hz timing generator and output stage for the battleship display. Scans the screen and drives the current pixel coordinate `x`/`y` to the combinational board renderer (generadorMatriz). Accepts that renderer's RGB back, registers it, and drives the DAC pins with aligned sync/blank. Also gives game logic a once-per-frame strobe, so the board matrices are updated only during vertical blanking.

## Interface
- `DIV`, 2, system clocks per pixel (50 MHz → 25 MHz pixel rate); must be ≥2
- `H_VIS`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48 — horizontal timing in pixels
- `V_VIS`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33 — vertical timing in lines
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  asynchronous active-low reset
- `red_in`/`green_in`/`blue_in`  in  8 each  colour from renderer for current `x`,`y`
- `x`  out  10  current horizontal count, 0..H_TOTAL-1
- `y`  out  10  current vertical count, 0..V_TOTAL-1
- `activo`  out  1  `x`<H_VIS and `y`<V_VIS (combinational from counters)
- `fin_cuadro`  out  1  one-clk pulse at start of vertical blanking
- `vga_clk`  out  1  pixel clock to DAC
- `hsync_n`/`vsync_n`  out  1 each  active-low syncs
- `blank_n`  out  1  low outside visible area
- `sync_n`  out  1  constant 0 (no sync-on-green)
- `red`/`green`/`blue`  out  8 each  registered pixel colour to DAC

## Operation
- Divider `div_cnt` counts 0..DIV-1 on every `clk`. `pix_en` is high when `div_cnt`==DIV-1. `vga_clk` is registered and is 1 when `div_cnt` ≥ DIV/2 (DIV=2: square wave, rising edge mid-pixel).
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- On `pix_en`, `x` increments. At `x`==H_TOTAL-1, `x`→0 and `y` increments. At `y`==V_TOTAL-1 with `x` wrap, `y`→0. No other state; the state is the counter pair.
- Output stage, registered on `pix_en`, computed from the pre-increment `x`,`y`:
  - `hsync_n` = 0 iff H_VIS+H_FP ≤ `x` < H_VIS+H_FP+H_SYNC
  - `vsync_n` = 0 iff V_VIS+V_FP ≤ `y` < V_VIS+V_FP+V_SYNC
  - `blank_n` = `activo`
  - RGB = inputs when `activo`, else 0
- `fin_cuadro` is 1 for exactly the `clk` cycle in which `pix_en` moves the counters to (`x`=0, `y`=V_VIS). This is exactly once per frame.
- Arithmetic: all compares are unsigned 10-bit. Counter maxima are 799 and 524. No overflow is possible with the default parameters.

## Timing
- Reset (async assert, sync release) sets:
  - `div_cnt`=0, `x`=0, `y`=0
  - `hsync_n`=1, `vsync_n`=1, `blank_n`=0, RGB=0, `vga_clk`=0, `fin_cuadro`=0
- Renderer contract: RGB inputs must be settled within one `clk` of an `x`/`y` change. Inputs are sampled on the next `pix_en`.
- Latency: counter value to pins is one pixel (DIV clks). Syncs, blank and RGB share that latency, so they stay mutually aligned.
- Line period is 800 pixels = 1600 clk. Frame period is 420 000 pixels = 840 000 clk.
- `hsync_n` low width is 96 pixels. `vsync_n` low width is 2 lines = 1600 pixels.
- Reset mid-frame: outputs return to reset values immediately (async). Scanning restarts at (0,0) and the first `pix_en` falls DIV clks after release. A partial frame is expected and no `fin_cuadro` is owed for it.

## Structure
- Package `vga_pkg` holds:
  - timing default constants and derived `H_TOTAL`/`V_TOTAL`
  - `typedef logic [9:0] coord_t` for `x`/`y`
  - `typedef struct {logic [7:0] r,g,b;} rgb_t`, shared with the renderer
- Sub-module `divisor_pixel` (parameter DIV) produces `pix_en` and `vga_clk`. Counters and output registers stay in the top.

## Test plan
- Reset held 10 clk, then released. Check reset values during reset; first `x` increment at clk 2 after release; `x` reaches 799 then 0 with `y`=1 at pixel 800.
- Free-run one line. Measure from output falling edge: `hsync_n` low for exactly 192 clk, first falling edge at pixel 656+1 latency, period 1600 clk.
- Free-run two frames. Check:
  - `vsync_n` low during registered lines 490–491 (3200 clk)
  - `fin_cuadro` pulses exactly twice, 840 000 clk apart, each coinciding with `x`=0, `y`=480
- Drive RGB inputs to constant 8'hFF/8'h00/8'hAA. Check:
  - outputs equal the inputs one pixel later while `blank_n`=1
  - outputs are 0 at `x`=640..799 and `y`≥480
- Drive RGB inputs = {`x`[7:0], `y`[7:0], 8'h55} (renderer model). Check output at each visible pixel equals the value for the coordinate one pixel earlier.
- Assert `rst_n` at `x`=300, `y`=200 for 3 clk. Check outputs go to reset values within the same clk; scanning resumes from (0,0); `fin_cuadro` next occurs at `y`=480 of the new frame.
